// File: rtl/mic_frame_tx.sv
`default_nettype none
// ============================================================================
// mic_frame_tx : I2S-style serial transmitter fed from a small sample FIFO.
// Revision     : 1.0
// ============================================================================
module mic_frame_tx #(
    parameter int SAMPLE_W = 18,
    parameter int SLOT_W   = 32,
    parameter int CLK_DIV  = 4,
    parameter int DEPTH    = 16
) (
    input  logic                     clk_25,
    input  logic                     rst_n,
    input  logic [SAMPLE_W-1:0]      s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     bclk,
    output logic                     ws,
    output logic                     sdata,
    output logic                     frame_start,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int c_div_w = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int c_bit_w = $clog2(2 * SLOT_W);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(2 * SLOT_W - 1);
    localparam logic [c_bit_w-1:0] c_ws_set     = c_bit_w'(SLOT_W - 1);
    localparam logic [c_bit_w-1:0] c_left_load  = c_bit_w'(1);
    localparam logic [c_bit_w-1:0] c_right_load = c_bit_w'(SLOT_W + 1);
    localparam logic [c_lvl_w-1:0] c_depth      = c_lvl_w'(DEPTH);

    logic [c_div_w-1:0]  div_q, div_d;
    logic                bclk_q, bclk_d;
    logic [c_bit_w-1:0]  bitcnt_q, bitcnt_d;
    logic                ws_q, ws_d;
    logic                sdata_q, sdata_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0]  level_q, level_d;
    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    logic                w_term;
    logic                w_fall;
    logic [c_bit_w-1:0]  w_bitcnt_nxt;
    logic                w_load;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [SAMPLE_W-1:0] w_head;

    // Full is judged on the registered level only, so a pop never frees a slot
    // for a push in the same cycle.
    assign s_ready = (level_q < c_depth);

    always_comb begin
        w_term       = (div_q == c_div_last);
        w_fall       = w_term && bclk_q;
        w_bitcnt_nxt = (bitcnt_q == c_bit_last) ? '0 : bitcnt_q + c_bit_w'(1);
        w_load       = w_fall && ((w_bitcnt_nxt == c_left_load) || (w_bitcnt_nxt == c_right_load));
        w_empty      = (level_q == '0);
        w_push       = s_valid && s_ready;
        w_pop        = w_load && !w_empty;
        w_head       = mem_q[rd_ptr_q];

        div_d         = w_term ? '0 : div_q + c_div_w'(1);
        bclk_d        = w_term ? ~bclk_q : bclk_q;
        bitcnt_d      = bitcnt_q;
        ws_d          = ws_q;
        sdata_d       = sdata_q;
        shift_d       = shift_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        wr_ptr_d      = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d      = w_pop ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        level_d       = level_q;

        if (w_push && !w_pop) begin
            level_d = level_q + c_lvl_w'(1);
        end else if (w_pop && !w_push) begin
            level_d = level_q - c_lvl_w'(1);
        end

        if (w_fall) begin
            bitcnt_d      = w_bitcnt_nxt;
            frame_start_d = (w_bitcnt_nxt == '0);
            if (w_bitcnt_nxt == c_ws_set) begin
                ws_d = 1'b1;
            end else if (w_bitcnt_nxt == c_bit_last) begin
                ws_d = 1'b0;
            end
            if (w_load) begin
                if (w_empty) begin
                    shift_d    = '0;
                    sdata_d    = 1'b0;
                    underrun_d = 1'b1;
                end else begin
                    // MSB goes straight onto the line; the rest waits in the shifter.
                    shift_d = {w_head[SAMPLE_W-2:0], 1'b0};
                    sdata_d = w_head[SAMPLE_W-1];
                end
            end else begin
                sdata_d = shift_q[SAMPLE_W-1];
                shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            bitcnt_q      <= '0;
            ws_q          <= 1'b0;
            sdata_q       <= 1'b0;
            shift_q       <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            bitcnt_q      <= bitcnt_d;
            ws_q          <= ws_d;
            sdata_q       <= sdata_d;
            shift_q       <= shift_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    always_ff @(posedge clk_25) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign bclk        = bclk_q;
    assign ws          = ws_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign level       = level_q;

endmodule
`default_nettype wire

// File: tb/tb_mic_frame_tx.sv
`default_nettype none
// tb_mic_frame_tx : scoreboard bench for the I2S-style frame transmitter.
module tb_mic_frame_tx;
    localparam int SAMPLE_W = 18;
    localparam int SLOT_W   = 32;
    localparam int CLK_DIV  = 4;
    localparam int DEPTH    = 16;
    localparam int c_frame_bits = 2 * SLOT_W;
    localparam int c_lvl_w      = $clog2(DEPTH) + 1;

    logic                clk_25  = 1'b0;
    logic                rst_n   = 1'b0;
    logic [SAMPLE_W-1:0] s_data  = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic                bclk;
    logic                ws;
    logic                sdata;
    logic                frame_start;
    logic                underrun;
    logic [c_lvl_w-1:0]  level;

    mic_frame_tx #(
        .SAMPLE_W (SAMPLE_W),
        .SLOT_W   (SLOT_W),
        .CLK_DIV  (CLK_DIV),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .bclk        (bclk),
        .ws          (ws),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk_25 = ~clk_25;

    int checks = 0;
    int errors = 0;

    // Reference model state, advanced on each rising clock edge
    int                  cyc  = 0;
    int                  mbit = 0;
    logic                mbclk = 1'b0;
    logic                mws = 1'b0;
    logic                exp_und = 1'b0;
    logic                exp_fs = 1'b0;
    logic [SAMPLE_W-1:0] mq[$];
    logic [SAMPLE_W-1:0] exp_slot[$];

    // Receiver state, sampled on falling clock edges
    logic              prev_bclk = 1'b0;
    int                rcnt = 0;
    logic              rcv_active = 1'b0;
    logic              rcv_left = 1'b0;
    logic [SLOT_W-1:0] rcv = '0;
    int                rcv_n = 0;
    int                und_seen = 0;
    int                slots_checked = 0;
    logic [SLOT_W-1:0] last_left = '1;
    logic [SLOT_W-1:0] last_right = '1;

    task automatic model_loop();
        logic term;
        logic fall;
        logic acc;
        forever begin
            @(posedge clk_25);
            if (!rst_n) begin
                cyc = 0; mbit = 0; mbclk = 1'b0; mws = 1'b0;
                exp_und = 1'b0; exp_fs = 1'b0;
                mq.delete();
                exp_slot.delete();
            end else begin
                acc     = s_valid && (mq.size() < DEPTH);
                term    = ((cyc % CLK_DIV) == CLK_DIV - 1);
                fall    = term && mbclk;
                exp_und = 1'b0;
                exp_fs  = 1'b0;
                if (term) mbclk = ~mbclk;
                if (fall) begin
                    mbit = (mbit + 1) % c_frame_bits;
                    if (mbit == SLOT_W - 1) mws = 1'b1;
                    if (mbit == c_frame_bits - 1) mws = 1'b0;
                    if (mbit == 0) exp_fs = 1'b1;
                    if (mbit == 1 || mbit == SLOT_W + 1) begin
                        if (mq.size() > 0) begin
                            exp_slot.push_back(mq.pop_front());
                        end else begin
                            exp_slot.push_back('0);
                            exp_und = 1'b1;
                        end
                    end
                end
                if (acc) mq.push_back(s_data);
                cyc++;
            end
        end
    endtask

    task automatic monitor_loop();
        int b;
        logic [SAMPLE_W-1:0] expv;
        forever begin
            @(negedge clk_25);
            if (!rst_n) begin
                prev_bclk = 1'b0; rcnt = 0; rcv_active = 1'b0;
            end else begin
                checks++;
                if (bclk !== mbclk) begin errors++; $display("FAIL bclk: got %b expected %b at %0t", bclk, mbclk, $time); end
                checks++;
                if (ws !== mws) begin errors++; $display("FAIL ws: got %b expected %b at %0t", ws, mws, $time); end
                checks++;
                if (underrun !== exp_und) begin errors++; $display("FAIL underrun: got %b expected %b at %0t", underrun, exp_und, $time); end
                checks++;
                if (frame_start !== exp_fs) begin errors++; $display("FAIL frame_start: got %b expected %b at %0t", frame_start, exp_fs, $time); end
                checks++;
                if (level !== c_lvl_w'(mq.size())) begin errors++; $display("FAIL level: got %0d expected %0d at %0t", level, mq.size(), $time); end
                checks++;
                if (s_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL s_ready: got %b expected %b at %0t", s_ready, (mq.size() < DEPTH), $time); end
                if (underrun === 1'b1) und_seen++;
                if (bclk === 1'b1 && prev_bclk === 1'b0) begin
                    b = rcnt % c_frame_bits;
                    rcnt++;
                    if (b == 1 || b == SLOT_W + 1) begin
                        rcv_active = 1'b1; rcv_left = (b == 1); rcv = '0; rcv_n = 0;
                    end
                    if (rcv_active) begin
                        rcv = {rcv[SLOT_W-2:0], sdata};
                        rcv_n++;
                        if (rcv_n == SLOT_W) begin
                            rcv_active = 1'b0;
                            if (rcv_left) last_left = rcv; else last_right = rcv;
                            slots_checked++;
                            checks++;
                            if (exp_slot.size() == 0) begin
                                errors++;
                                $display("FAIL slot_order: got slot %h expected none queued at %0t", rcv, $time);
                            end else begin
                                expv = exp_slot.pop_front();
                                if (rcv !== {expv, {(SLOT_W-SAMPLE_W){1'b0}}}) begin
                                    errors++;
                                    $display("FAIL slot_data: got %h expected %h at %0t", rcv, {expv, {(SLOT_W-SAMPLE_W){1'b0}}}, $time);
                                end
                            end
                        end
                    end
                end
                prev_bclk = bclk;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_25);
    endtask

    task automatic do_reset();
        @(negedge clk_25);
        #3 rst_n = 1'b0;
        s_valid = 1'b0;
        wait_cycles(3);
        #2 rst_n = 1'b1;
        last_left  = '1;
        last_right = '1;
    endtask

    task automatic test_reset();
        int first_rise;
        int second_rise;
        logic prev;
        first_rise = -1; second_rise = -1; prev = 1'b0;
        wait_cycles(2);
        #2 rst_n = 1'b1;
        for (int m = 1; m <= 300; m++) begin
            @(negedge clk_25);
            if (m <= 3) begin s_valid = 1'b1; s_data = 18'(m * 18'h1111); end
            else s_valid = 1'b0;
            if (bclk === 1'b1 && prev === 1'b0) begin
                if (first_rise < 0) first_rise = m;
                else if (second_rise < 0) second_rise = m;
            end
            prev = bclk;
        end
        checks++;
        if (first_rise != 4) begin errors++; $display("FAIL first_rise: got %0d expected 4", first_rise); end
        checks++;
        if (second_rise - first_rise != 8) begin errors++; $display("FAIL bclk_period: got %0d expected 8", second_rise - first_rise); end
        @(negedge clk_25);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bclk, ws, sdata, frame_start, underrun} !== 5'b0) begin
            errors++; $display("FAIL async_reset_outs: got %b expected 00000", {bclk, ws, sdata, frame_start, underrun});
        end
        checks++;
        if (level !== '0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_fifo: got level=%0d s_ready=%b expected level=0 s_ready=1", level, s_ready);
        end
    endtask

    task automatic test_basic();
        int u0;
        int s0;
        do_reset();
        u0 = und_seen; s0 = slots_checked;
        @(negedge clk_25); s_valid = 1'b1; s_data = 18'h2AAAA;
        @(negedge clk_25); s_data = 18'h15555;
        @(negedge clk_25); s_valid = 1'b0;
        wait_cycles(515);
        checks++;
        if (und_seen - u0 != 0) begin errors++; $display("FAIL basic_underrun: got %0d expected 0", und_seen - u0); end
        checks++;
        if (slots_checked - s0 != 2) begin errors++; $display("FAIL basic_slots: got %0d expected 2", slots_checked - s0); end
        checks++;
        if (last_left !== 32'hAAAA8000) begin errors++; $display("FAIL basic_left: got %h expected aaaa8000", last_left); end
        checks++;
        if (last_right !== 32'h55554000) begin errors++; $display("FAIL basic_right: got %h expected 55554000", last_right); end
    endtask

    task automatic test_empty();
        int u0;
        int fs_n;
        int fs_first;
        int fs_second;
        logic sd_bad;
        do_reset();
        u0 = und_seen; fs_n = 0; fs_first = -1; fs_second = -1; sd_bad = 1'b0;
        for (int m = 1; m <= 1100; m++) begin
            @(negedge clk_25);
            if (sdata !== 1'b0) sd_bad = 1'b1;
            if (frame_start === 1'b1) begin
                fs_n++;
                if (fs_first < 0) fs_first = m;
                else if (fs_second < 0) fs_second = m;
            end
        end
        checks++;
        if (und_seen - u0 != 5) begin errors++; $display("FAIL empty_underruns: got %0d expected 5", und_seen - u0); end
        checks++;
        if (sd_bad) begin errors++; $display("FAIL empty_sdata: got 1 expected 0"); end
        checks++;
        if (fs_n != 2 || fs_first != 512 || fs_second - fs_first != 512) begin
            errors++; $display("FAIL frame_start_spacing: got n=%0d first=%0d second=%0d expected n=2 first=512 gap=512", fs_n, fs_first, fs_second);
        end
    endtask

    task automatic test_full();
        int s0;
        int n;
        do_reset();
        wait_cycles(8);
        s0 = slots_checked;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_25);
            s_valid = 1'b1;
            s_data  = 18'($urandom);
        end
        @(negedge clk_25);
        s_data = 18'h3C0F3;
        checks++;
        if (level !== c_lvl_w'(DEPTH) || s_ready !== 1'b0) begin
            errors++; $display("FAIL full_level: got level=%0d s_ready=%b expected level=16 s_ready=0", level, s_ready);
        end
        n = 0;
        while (s_ready !== 1'b1 && n < 400) begin
            @(negedge clk_25);
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_timeout: got s_ready=%b expected 1", s_ready); end
        checks++;
        if (level !== c_lvl_w'(DEPTH - 1)) begin errors++; $display("FAIL full_after_pop: got %0d expected 15", level); end
        @(negedge clk_25);
        s_valid = 1'b0;
        checks++;
        if (level !== c_lvl_w'(DEPTH)) begin errors++; $display("FAIL full_17th_push: got %0d expected 16", level); end
        wait_cycles(4700);
        checks++;
        if (level !== '0) begin errors++; $display("FAIL full_drain_level: got %0d expected 0", level); end
        checks++;
        if (slots_checked - s0 < DEPTH + 2) begin errors++; $display("FAIL full_drain_slots: got %0d expected >= 18", slots_checked - s0); end
    endtask

    task automatic test_push_at_load();
        int u0;
        do_reset();
        u0 = und_seen;
        wait_cycles(7);
        s_valid = 1'b1;
        s_data  = 18'h20001;
        @(negedge clk_25);
        s_valid = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL load_push_underrun: got %b expected 1", underrun); end
        checks++;
        if (level !== c_lvl_w'(1)) begin errors++; $display("FAIL load_push_level: got %0d expected 1", level); end
        wait_cycles(510);
        checks++;
        if (last_left !== '0) begin errors++; $display("FAIL load_push_left: got %h expected 00000000", last_left); end
        checks++;
        if (last_right !== 32'h80004000) begin errors++; $display("FAIL load_push_right: got %h expected 80004000", last_right); end
        checks++;
        if (und_seen - u0 != 1) begin errors++; $display("FAIL load_push_underrun_count: got %0d expected 1", und_seen - u0); end
    endtask

    initial begin
        fork
            model_loop();
            monitor_loop();
        join_none
        test_reset();
        test_basic();
        test_empty();
        test_full();
        test_push_at_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
